// File: rtl/digit_frame_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : digit_frame_capture_pkg
// Description : Shared constants, FSM state encoding and helper function for
//               the digit-scan receive path.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package digit_frame_capture_pkg;

   localparam int NUM_DIGITS = 8;
   localparam int DIGIT_W    = 4;
   localparam int WORD_W     = NUM_DIGITS * DIGIT_W;
   localparam int IDX_W      = $clog2(NUM_DIGITS);

   localparam logic [IDX_W-1:0] C_LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [IDX_W-1:0] C_FIRST_IDX = IDX_W'(1);

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_COLLECT = 1'b1
   } state_t;

   // A nibble outside 0..9 is not a valid BCD digit.
   function automatic logic digit_not_bcd(input logic [DIGIT_W-1:0] d);
      return (d > 4'd9);
   endfunction

endpackage
`default_nettype wire

// File: rtl/digit_frame_capture.sv
`default_nettype none
// ============================================================================
// Module      : digit_frame_capture
// Description : Reassembles a time-multiplexed nibble stream (digit 0 first,
//               one digit per digit_valid) into a 32-bit packed word, with
//               resync/timeout abort detection and optional BCD checking.
// Ports       : clk, rst_n (async active-low)
//               digit_in[3:0], digit_valid, frame_start  - scan input
//               word_out[31:0], word_valid               - committed frame
//               frame_err, bcd_err                       - one-cycle pulses
//               busy                                     - frame in progress
// Revision    : 1.0 - initial release
// ============================================================================
module digit_frame_capture
   import digit_frame_capture_pkg::*;
#(
   parameter int TIMEOUT   = 1023,
   parameter int BCD_CHECK = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [DIGIT_W-1:0]  digit_in,
   input  logic                digit_valid,
   input  logic                frame_start,
   output logic [WORD_W-1:0]   word_out,
   output logic                word_valid,
   output logic                frame_err,
   output logic                bcd_err,
   output logic                busy
);

   localparam int TMR_W = $clog2(TIMEOUT + 1);
   // Abort fires on the TIMEOUT-th consecutive idle cycle.
   localparam logic [TMR_W-1:0] C_TMR_LAST = TMR_W'(TIMEOUT - 1);

   state_t               r_state;
   state_t               w_state_next;
   logic [IDX_W-1:0]     r_idx;
   logic [TMR_W-1:0]     r_timer;
   logic [WORD_W-1:0]    r_shadow;
   logic                 r_bcd_flag;

   logic                 w_start;     // new frame begins (incl. early restart)
   logic                 w_restart;   // frame_start while collecting
   logic                 w_store;     // next digit of current frame
   logic                 w_commit;    // last digit stored
   logic                 w_timeout;   // idle too long inside a frame
   logic                 w_digit_bad;
   logic [WORD_W-1:0]    w_shadow_next;

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:    if (w_start) w_state_next = ST_COLLECT;
         ST_COLLECT: if (w_commit || w_timeout) w_state_next = ST_IDLE;
         default:    w_state_next = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- decode
   always_comb begin
      w_start     = 1'b0;
      w_restart   = 1'b0;
      w_store     = 1'b0;
      w_commit    = 1'b0;
      w_timeout   = 1'b0;
      w_digit_bad = digit_not_bcd(digit_in);
      case (r_state)
         ST_IDLE: begin
            // Stray digits without frame_start are ignored while hunting.
            w_start = digit_valid && frame_start;
         end
         ST_COLLECT: begin
            // frame_start wins over a commit on the last digit.
            w_start   = digit_valid && frame_start;
            w_restart = digit_valid && frame_start;
            w_store   = digit_valid && !frame_start;
            w_commit  = w_store && (r_idx == C_LAST_IDX);
            w_timeout = !digit_valid && (r_timer == C_TMR_LAST);
         end
         default: ;
      endcase
   end

   always_comb begin
      w_shadow_next = r_shadow;
      w_shadow_next[{r_idx, 2'b00} +: DIGIT_W] = digit_in;
   end

   assign busy = (r_state == ST_COLLECT);

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx      <= '0;
         r_timer    <= '0;
         r_shadow   <= '0;
         r_bcd_flag <= 1'b0;
         word_out   <= '0;
         word_valid <= 1'b0;
         frame_err  <= 1'b0;
         bcd_err    <= 1'b0;
      end else begin
         word_valid <= 1'b0;
         frame_err  <= w_restart || w_timeout;
         bcd_err    <= 1'b0;

         if (w_start) begin
            r_shadow[DIGIT_W-1:0] <= digit_in;
            r_idx                 <= C_FIRST_IDX;
            r_timer               <= '0;
            r_bcd_flag            <= w_digit_bad;
         end else if (w_store) begin
            r_shadow   <= w_shadow_next;
            r_timer    <= '0;
            r_bcd_flag <= r_bcd_flag || w_digit_bad;
            if (w_commit) begin
               word_out   <= w_shadow_next;
               word_valid <= 1'b1;
               bcd_err    <= (BCD_CHECK != 0) && (r_bcd_flag || w_digit_bad);
               r_idx      <= '0;
            end else begin
               r_idx <= r_idx + 1'b1;
            end
         end else if (w_timeout) begin
            r_idx      <= '0;
            r_timer    <= '0;
            r_bcd_flag <= 1'b0;
         end else if (r_state == ST_COLLECT) begin
            r_timer <= r_timer + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire
